dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, memory access cycles per transaction; legal range 1..15.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive pipeline grants allowed while D_REQ waits; legal range 1..15.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 P_REQ  in  1  MEM-stage access request (MemWriteM | MemtoRegM).
REQ-006 P_WE  in  1  MEM-stage write enable.
REQ-007 P_ADDR  in  32  MEM-stage address (ALUOutM).
REQ-008 P_WDATA  in  32  MEM-stage store data (WriteDataM).
REQ-009 P_RDATA  out  32  load data returned to MEM stage.
REQ-010 P_STALL  out  1  freeze pipeline while the MEM-stage access is incomplete.
REQ-011 D_REQ, D_WE  in  1 each  loader/DMA request and write enable.
REQ-012 D_ADDR, D_WDATA  in  32 each  loader address and store data.
REQ-013 D_ACK  out  1  one-cycle completion pulse for loader.
REQ-014 D_RDATA  out  32  loader read data.
REQ-015 MEM_A, MEM_WD  out  32 each  data-memory address and write data.
REQ-016 MEM_WE  out  1  data-memory write enable.
REQ-017 MEM_RD  in  32  data-memory read data.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any request, ACCESS->RESP after LATENCY cycles, RESP->IDLE unconditionally.
REQ-019 In IDLE with a request, the arbiter grants one owner, latches its WE/ADDR/WDATA, loads the access counter with LATENCY-1, and enters ACCESS next edge.
REQ-020 Arbitration: P wins by default; D wins if only D requests, or if both request and the starve counter equals STARVE_LIMIT.
REQ-021 Starve counter increments on each P grant while D_REQ=1, saturates at STARVE_LIMIT, and clears on any D grant.
REQ-022 In ACCESS, MEM_A/MEM_WD drive the latched address/data every cycle; the counter decrements each cycle; the last ACCESS cycle is counter==0.
REQ-023 MEM_WE = latched WE only in the last ACCESS cycle: exactly one write pulse per write transaction; MEM_WE=0 in every other state and cycle.
REQ-024 On the edge leaving the last ACCESS cycle, MEM_RD is captured into P_RDATA (owner P) or D_RDATA (owner D); the other data output holds. For writes, the data output holds its previous value.
REQ-025 In RESP, owner P: P_STALL=0; owner D: D_ACK=1 for exactly this cycle.
REQ-026 P_STALL = P_REQ AND NOT (state==RESP AND owner==P), combinational.
REQ-027 Latency from IDLE: request seen in cycle 0, ACCESS in cycles 1..LATENCY, RESP in cycle LATENCY+1. Back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-028 Requesters hold their request fields stable until completion. Changes to request fields after grant are ignored.
REQ-029 If D_REQ drops mid-transaction, the transaction completes and D_ACK still pulses.
REQ-030 A request arriving during ACCESS or RESP waits; it is arbitrated in the next IDLE cycle.
REQ-031 MEM_A/MEM_WD hold their last values in IDLE and RESP.

Reset
REQ-032 RESET_N=0 immediately forces: state IDLE, MEM_WE=0, D_ACK=0, MEM_A=0, MEM_WD=0, P_RDATA=0, D_RDATA=0, counters=0; P_STALL=P_REQ.
REQ-033 Reset during ACCESS aborts the transaction with no memory write and no D_ACK. After release, the first edge may arbitrate.

Verification
REQ-034 LATENCY=2, P load addr 0x10, memory[0x10]=0xCAFEF00D -> P_STALL=1 in cycles 0-2, 0 in cycle 3; P_RDATA=0xCAFEF00D in cycle 3.
REQ-035 P store 0x00000020<-0x12345678 -> exactly one MEM_WE pulse, in cycle 2, with MEM_A=0x20 and MEM_WD=0x12345678.
REQ-036 P_REQ and D_REQ held continuously, STARVE_LIMIT=4 -> grant order P,P,P,P,D,P...; exactly one D_ACK per D grant.
REQ-037 D read addr 0x40 while P idle -> D_ACK pulses one cycle in cycle 3; D_RDATA=memory[0x40]; P_RDATA unchanged.
REQ-038 RESET_N low during the first ACCESS cycle of a store -> MEM_WE never asserted; all outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between the MEM stage and a loader/DMA port
module dmem_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        P_REQ,
  input  logic        P_WE,
  input  logic [31:0] P_ADDR,
  input  logic [31:0] P_WDATA,
  output logic [31:0] P_RDATA,
  output logic        P_STALL,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RD
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     stateNext;
  logic       ownerD;
  logic       weLat;
  logic [3:0] accCnt;
  logic [3:0] starveCnt;

  logic anyReq;
  logic grantD;
  logic lastAccess;

  assign anyReq     = P_REQ | D_REQ;
  assign grantD     = D_REQ & (~P_REQ | (starveCnt == STARVE_MAX));
  assign lastAccess = (state == ACCESS) && (accCnt == 4'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (lastAccess) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // MEM_A/MEM_WD are the latched request itself, so they naturally hold outside ACCESS
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ownerD    <= 1'b0;
      weLat     <= 1'b0;
      MEM_A     <= '0;
      MEM_WD    <= '0;
      accCnt    <= '0;
      starveCnt <= '0;
      P_RDATA   <= '0;
      D_RDATA   <= '0;
    end else begin
      if (state == IDLE && anyReq) begin
        ownerD <= grantD;
        weLat  <= grantD ? D_WE : P_WE;
        MEM_A  <= grantD ? D_ADDR : P_ADDR;
        MEM_WD <= grantD ? D_WDATA : P_WDATA;
        accCnt <= CNT_LOAD;
        if (grantD)                                starveCnt <= '0;
        else if (D_REQ && starveCnt != STARVE_MAX) starveCnt <= starveCnt + 4'd1;
      end else if (state == ACCESS && accCnt != 4'd0) begin
        accCnt <= accCnt - 4'd1;
      end

      if (lastAccess && !weLat) begin
        if (ownerD) D_RDATA <= MEM_RD;
        else        P_RDATA <= MEM_RD;
      end
    end
  end

  assign MEM_WE  = lastAccess & weLat;
  assign D_ACK   = (state == RESP) & ownerD;
  assign P_STALL = P_REQ & ~((state == RESP) & ~ownerD);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        P_REQ, P_WE;
  logic [31:0] P_ADDR, P_WDATA, P_RDATA;
  logic        P_STALL;
  logic        D_REQ, D_WE;
  logic [31:0] D_ADDR, D_WDATA, D_RDATA;
  logic        D_ACK;
  logic [31:0] MEM_A, MEM_WD, MEM_RD;
  logic        MEM_WE;

  logic [31:0] mem [0:255];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          weCount = 0;

  dmem_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .P_REQ(P_REQ), .P_WE(P_WE), .P_ADDR(P_ADDR), .P_WDATA(P_WDATA),
    .P_RDATA(P_RDATA), .P_STALL(P_STALL),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Word-addressed memory model with combinational read
  assign MEM_RD = mem[MEM_A[9:2]];
  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_A[9:2]] <= MEM_WD;
      weCount++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         weBefore;
    int         nResp;
    logic       ownSeq [0:5];
    int         cycSeq [0:5];
    int         ackCycles;
    logic       expOwn [0:5];

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hCAFEF00D;
    mem[8'h10] = 32'hA5A50040;
    mem[8'h40] = 32'h11110100;
    mem[8'h80] = 32'h22220200;

    RESET_N = 1'b0;
    P_REQ = 0; P_WE = 0; P_ADDR = 0; P_WDATA = 0;
    D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0;
    tick();

    // Reset values
    chk("rst_mem_we", {31'b0, MEM_WE}, 32'd0);
    chk("rst_d_ack", {31'b0, D_ACK}, 32'd0);
    chk("rst_mem_a", MEM_A, 32'h0);
    chk("rst_mem_wd", MEM_WD, 32'h0);
    chk("rst_p_rdata", P_RDATA, 32'h0);
    chk("rst_d_rdata", D_RDATA, 32'h0);
    P_REQ = 1;
    #1;
    chk("rst_p_stall_follows_req", {31'b0, P_STALL}, 32'd1);
    P_REQ = 0;
    tick();
    RESET_N = 1'b1;
    tick();

    // P load 0x10
    P_REQ = 1; P_WE = 0; P_ADDR = 32'h10;
    #1;
    chk("load_stall_c0", {31'b0, P_STALL}, 32'd1);
    tick();
    chk("load_stall_c1", {31'b0, P_STALL}, 32'd1);
    chk("load_mem_a_c1", MEM_A, 32'h10);
    tick();
    chk("load_stall_c2", {31'b0, P_STALL}, 32'd1);
    chk("load_no_we_c2", {31'b0, MEM_WE}, 32'd0);
    tick();
    chk("load_stall_c3", {31'b0, P_STALL}, 32'd0);
    chk("load_rdata_c3", P_RDATA, 32'hCAFEF00D);
    chk("load_no_dack_c3", {31'b0, D_ACK}, 32'd0);
    P_REQ = 0;
    tick();

    // P store 0x20 <- 0x12345678
    weBefore = weCount;
    P_REQ = 1; P_WE = 1; P_ADDR = 32'h20; P_WDATA = 32'h12345678;
    #1;
    chk("store_no_we_c0", {31'b0, MEM_WE}, 32'd0);
    tick();
    chk("store_no_we_c1", {31'b0, MEM_WE}, 32'd0);
    tick();
    chk("store_we_c2", {31'b0, MEM_WE}, 32'd1);
    chk("store_mem_a_c2", MEM_A, 32'h20);
    chk("store_mem_wd_c2", MEM_WD, 32'h12345678);
    tick();
    chk("store_no_we_c3", {31'b0, MEM_WE}, 32'd0);
    chk("store_stall_c3", {31'b0, P_STALL}, 32'd0);
    chk("store_p_rdata_holds", P_RDATA, 32'hCAFEF00D);
    P_REQ = 0; P_WE = 0;
    tick();
    chk("store_one_pulse", 32'(weCount - weBefore), 32'd1);
    chk("store_mem_written", mem[8'h08], 32'h12345678);
    chk("store_mem_a_holds_idle", MEM_A, 32'h20);

    // D read 0x40 with P idle
    D_REQ = 1; D_WE = 0; D_ADDR = 32'h40;
    #1;
    chk("dread_no_ack_c0", {31'b0, D_ACK}, 32'd0);
    tick();
    chk("dread_no_ack_c1", {31'b0, D_ACK}, 32'd0);
    tick();
    chk("dread_no_ack_c2", {31'b0, D_ACK}, 32'd0);
    tick();
    chk("dread_ack_c3", {31'b0, D_ACK}, 32'd1);
    chk("dread_rdata_c3", D_RDATA, 32'hA5A50040);
    chk("dread_p_rdata_holds", P_RDATA, 32'hCAFEF00D);
    D_REQ = 0;
    tick();
    chk("dread_ack_one_cycle", {31'b0, D_ACK}, 32'd0);

    // Starvation: both held continuously
    expOwn[0] = 0; expOwn[1] = 0; expOwn[2] = 0; expOwn[3] = 0; expOwn[4] = 1; expOwn[5] = 0;
    nResp = 0;
    ackCycles = 0;
    P_REQ = 1; P_WE = 0; P_ADDR = 32'h100;
    D_REQ = 1; D_WE = 0; D_ADDR = 32'h200;
    for (int cyc = 0; cyc < 24; cyc++) begin
      #1;
      if (D_ACK) ackCycles++;
      if (nResp < 6 && (D_ACK || !P_STALL)) begin
        ownSeq[nResp] = D_ACK;
        cycSeq[nResp] = cyc;
        nResp++;
      end
      if (cyc < 23) tick();
    end
    chk("starve_resp_count", 32'(nResp), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < nResp) begin
        chk($sformatf("starve_owner_%0d", i), {31'b0, ownSeq[i]}, {31'b0, expOwn[i]});
        chk($sformatf("starve_resp_cycle_%0d", i), 32'(cycSeq[i]), 32'(4 * i + 3));
      end
    end
    chk("starve_d_ack_cycles", 32'(ackCycles), 32'd1);
    chk("starve_d_rdata", D_RDATA, 32'h22220200);
    chk("starve_p_rdata", P_RDATA, 32'h11110100);
    P_REQ = 0; D_REQ = 0;
    tick();

    // Reset during first ACCESS cycle of a store
    weBefore = weCount;
    P_REQ = 1; P_WE = 1; P_ADDR = 32'h30; P_WDATA = 32'hDEADBEEF;
    tick();
    RESET_N = 1'b0;
    #1;
    chk("abort_mem_we", {31'b0, MEM_WE}, 32'd0);
    chk("abort_mem_a", MEM_A, 32'h0);
    chk("abort_mem_wd", MEM_WD, 32'h0);
    chk("abort_p_rdata", P_RDATA, 32'h0);
    chk("abort_d_rdata", D_RDATA, 32'h0);
    chk("abort_d_ack", {31'b0, D_ACK}, 32'd0);
    chk("abort_p_stall", {31'b0, P_STALL}, 32'd1);
    P_REQ = 0; P_WE = 0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    chk("abort_no_write", 32'(weCount - weBefore), 32'd0);
    chk("abort_mem_untouched", mem[8'h0C], 32'h0);

    // Next request after reset completes normally
    P_REQ = 1; P_WE = 0; P_ADDR = 32'h10;
    tick();
    tick();
    chk("post_rst_stall_c2", {31'b0, P_STALL}, 32'd1);
    tick();
    chk("post_rst_stall_c3", {31'b0, P_STALL}, 32'd0);
    chk("post_rst_rdata_c3", P_RDATA, 32'hCAFEF00D);
    P_REQ = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
